// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard-control slice: default
// specifier width, hazard FSM state encoding and the hard-wired zero register.
package pipeline_pkg;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int ZERO_REG       = 0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Register-specifier comparator: a source hits a destination only when the
// source is really read, the specifiers are equal and the destination is not
// the zero register (writes to $zero never create a dependence).
module hazard_match
   import pipeline_pkg::*;
#(
   parameter int W = REG_ADDR_W_DEF
) (
   input  logic [W-1:0] src,
   input  logic         src_used,
   input  logic [W-1:0] dst,
   output logic         hit
);

   // Pure combinational compare, zero latency into the stall path
   assign hit = src_used & (src == dst) & (dst != W'(ZERO_REG));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage MIPS32 pipeline: load-use stalls with a
// multi-cycle penalty, optional no-forwarding ALU stalls, branch flushes,
// data-memory wait freezing and saturating stall/flush event counters.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W       = REG_ADDR_W_DEF,
   parameter int LOAD_USE_PENALTY = 1,
   parameter int FWD_EN           = 1,
   parameter int CNT_W            = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_ex_memread,
   input  logic                  id_ex_regwrite,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  ex_mem_regwrite,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic [REG_ADDR_W-1:0] if_id_rs,
   input  logic [REG_ADDR_W-1:0] if_id_rt,
   input  logic                  if_id_uses_rt,
   input  logic                  branch_taken,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  pipe_freeze,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic       NO_FWD = (FWD_EN == 0);
   localparam logic       MULTI  = (LOAD_USE_PENALTY > 1);
   localparam logic [1:0] PEN_M1 = 2'(LOAD_USE_PENALTY - 1);

   // Comparator array: bit0 = rs/rt against EX destination, bit1 = against MEM
   logic [1:0][1:0] hit;   // [dst][src]: src 0 = rs, 1 = rt
   logic [1:0]      dst_hit;

   for (genvar d = 0; d < 2; d++) begin : g_dst
      for (genvar s = 0; s < 2; s++) begin : g_src
         hazard_match #(.W(REG_ADDR_W)) u_match (
            .src      ((s == 0) ? if_id_rs : if_id_rt),
            .src_used ((s == 0) ? 1'b1 : if_id_uses_rt),
            .dst      ((d == 0) ? id_ex_rd : ex_mem_rd),
            .hit      (hit[d][s])
         );
      end
      assign dst_hit[d] = |hit[d];
   end

   hz_state_t  state, saved_state, eff_state;
   logic [1:0] remaining;
   logic       lu, ah, freeze, flush, stall;

   // Hazard classification for the current cycle, highest priority first
   always_comb begin
      lu        = id_ex_memread & dst_hit[0];
      ah        = NO_FWD & ((id_ex_regwrite & dst_hit[0]) | (ex_mem_regwrite & dst_hit[1]));
      // Leaving a memory wait resumes the interrupted state in the same cycle
      eff_state = (state == ST_MEM_WAIT) ? saved_state : state;
      freeze    = ~dmem_ready;
      flush     = dmem_ready & branch_taken;
      stall     = dmem_ready & ~branch_taken & ((eff_state == ST_LU_STALL) | lu | ah);
   end

   // Pipeline control outputs; reset forces the normal-flow values
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      if (!reset) begin
         if (freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
         end else if (flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   // Load-use stall FSM with memory-wait save/restore
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         saved_state <= ST_IDLE;
         remaining   <= 2'd0;
      end else if (freeze) begin
         if (state != ST_MEM_WAIT) begin
            saved_state <= state;
            state       <= ST_MEM_WAIT;
         end
      end else if (flush) begin
         state     <= ST_IDLE;
         remaining <= 2'd0;
      end else if (eff_state == ST_LU_STALL) begin
         if (remaining <= 2'd1) begin
            state     <= ST_IDLE;
            remaining <= 2'd0;
         end else begin
            state     <= ST_LU_STALL;
            remaining <= remaining - 2'd1;
         end
      end else if (lu && MULTI) begin
         // The detecting cycle is the first stall; the rest are owed here
         state     <= ST_LU_STALL;
         remaining <= PEN_M1;
      end else begin
         state <= ST_IDLE;
      end
   end

   // Saturating event counters; frozen cycles are not counted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances share one stimulus stream,
// A (penalty 3, no forwarding, 4-bit counters) and B (penalty 2, forwarding).
// A reference model tracks owed stall cycles and event totals per instance.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       id_ex_memread = 0, id_ex_regwrite = 0, ex_mem_regwrite = 0;
   logic [4:0] id_ex_rd = 0, ex_mem_rd = 0, if_id_rs = 0, if_id_rt = 0;
   logic       if_id_uses_rt = 0, branch_taken = 0, dmem_ready = 1;

   logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, pipe_freeze_a;
   logic [3:0]  stall_cnt_a, flush_cnt_a;
   logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, pipe_freeze_b;
   logic [15:0] stall_cnt_b, flush_cnt_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_PENALTY(3), .FWD_EN(0), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
      .id_ex_rd(id_ex_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
      .branch_taken(branch_taken), .dmem_ready(dmem_ready), .pc_write(pc_write_a),
      .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a), .id_ex_bubble(id_ex_bubble_a),
      .pipe_freeze(pipe_freeze_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_PENALTY(2), .FWD_EN(1), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
      .id_ex_rd(id_ex_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
      .branch_taken(branch_taken), .dmem_ready(dmem_ready), .pc_write(pc_write_b),
      .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b), .id_ex_bubble(id_ex_bubble_b),
      .pipe_freeze(pipe_freeze_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

   // Output bundles ordered {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
   localparam logic [4:0] O_NORM = 5'b11000;
   localparam logic [4:0] O_FRZ  = 5'b00001;
   localparam logic [4:0] O_FLSH = 5'b11110;
   localparam logic [4:0] O_STL  = 5'b00010;

   typedef struct {
      logic       memread, regwrite;
      logic [4:0] rd;
      logic       mregwrite;
      logic [4:0] mrd, rs, rt;
      logic       uses_rt, br, dready;
      logic [4:0] exp_a;
   } vec_t;

   vec_t tbl[$];

   // ---------------- reference model ----------------
   int m_left[2];   // stall cycles still owed by an accepted load-use hazard
   int m_sc[2];
   int m_fc[2];

   function automatic int pen(int k);  return (k == 0) ? 3 : 2;      endfunction
   function automatic bit fwd(int k);  return (k != 0);              endfunction
   function automatic int cmax(int k); return (k == 0) ? 15 : 65535; endfunction

   function automatic bit src_hit(logic [4:0] d);
      return (d != 0) && ((if_id_rs == d) || (if_id_uses_rt && if_id_rt == d));
   endfunction

   function automatic bit m_lu();
      return id_ex_memread && src_hit(id_ex_rd);
   endfunction

   function automatic bit m_ah(int k);
      if (fwd(k)) return 1'b0;
      return (id_ex_regwrite && src_hit(id_ex_rd)) || (ex_mem_regwrite && src_hit(ex_mem_rd));
   endfunction

   // 0 normal, 1 freeze, 2 flush, 3 stall
   function automatic int m_kind(int k);
      if (reset)                             return 0;
      if (!dmem_ready)                       return 1;
      if (branch_taken)                      return 2;
      if (m_left[k] > 0 || m_lu() || m_ah(k)) return 3;
      return 0;
   endfunction

   function automatic logic [4:0] kind_out(int kd);
      case (kd)
         1:       return O_FRZ;
         2:       return O_FLSH;
         3:       return O_STL;
         default: return O_NORM;
      endcase
   endfunction

   task automatic m_clear();
      for (int k = 0; k < 2; k++) begin
         m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end
   endtask

   task automatic m_edge();
      int kd;
      if (reset) begin
         m_clear();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         kd = m_kind(k);
         if (kd == 2) begin
            m_left[k] = 0;
            if (m_fc[k] < cmax(k)) m_fc[k]++;
         end else if (kd == 3) begin
            if (m_left[k] > 0)  m_left[k]--;
            else if (m_lu())    m_left[k] = pen(k) - 1;
            if (m_sc[k] < cmax(k)) m_sc[k]++;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] outs_a();
      return {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, pipe_freeze_a};
   endfunction
   function automatic logic [4:0] outs_b();
      return {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, pipe_freeze_b};
   endfunction

   task automatic check_model(string name);
      chk({name, ".outs_a"}, 32'(outs_a()), 32'(kind_out(m_kind(0))));
      chk({name, ".outs_b"}, 32'(outs_b()), 32'(kind_out(m_kind(1))));
      chk({name, ".stall_a"}, 32'(stall_cnt_a), 32'(m_sc[0]));
      chk({name, ".flush_a"}, 32'(flush_cnt_a), 32'(m_fc[0]));
      chk({name, ".stall_b"}, 32'(stall_cnt_b), 32'(m_sc[1]));
      chk({name, ".flush_b"}, 32'(flush_cnt_b), 32'(m_fc[1]));
   endtask

   // One cycle: inputs already driven, sample at negedge, then advance model
   task automatic step(string name, bit use_exp, logic [4:0] exp_a);
      @(negedge clk);
      if (use_exp) chk({name, ".tbl_a"}, 32'(outs_a()), 32'(exp_a));
      check_model(name);
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic drive(vec_t v);
      id_ex_memread = v.memread;   id_ex_regwrite = v.regwrite; id_ex_rd = v.rd;
      ex_mem_regwrite = v.mregwrite; ex_mem_rd = v.mrd;
      if_id_rs = v.rs; if_id_rt = v.rt; if_id_uses_rt = v.uses_rt;
      branch_taken = v.br; dmem_ready = v.dready;
   endtask

   function automatic vec_t mk(logic memread, logic regwrite, logic [4:0] rd, logic mregwrite,
                               logic [4:0] mrd, logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                               logic br, logic dready, logic [4:0] exp_a);
      vec_t v;
      v.memread = memread; v.regwrite = regwrite; v.rd = rd; v.mregwrite = mregwrite;
      v.mrd = mrd; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.br = br; v.dready = dready;
      v.exp_a = exp_a;
      return v;
   endfunction

   initial begin
      vec_t idle, lw8, ahv;
      m_clear();
      idle = mk(0,0,0, 0,0, 0,0,0, 0,1, O_NORM);
      lw8  = mk(1,0,8, 0,0, 8,0,0, 0,1, O_STL);
      ahv  = mk(0,1,5, 0,0, 5,0,0, 0,1, O_STL);

      // Reset held: a load-use pattern must not disturb the normal outputs
      drive(lw8);
      step("rst_hold", 1'b1, O_NORM);
      drive(idle);
      reset = 1'b0;

      // Directed table; exp_a is the instance-A (penalty 3, no forwarding) view
      tbl.push_back(idle);                                       // normal
      tbl.push_back(lw8);                                        // LU detect
      tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,1, O_STL));          // owed stall 2
      tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,1, O_STL));          // owed stall 3
      tbl.push_back(idle);                                       // back to normal
      tbl.push_back(mk(1,0,0, 0,0, 0,0,0, 0,1, O_NORM));         // $zero load
      tbl.push_back(mk(0,0,0, 1,9, 0,9,1, 0,1, O_STL));          // MEM RAW on rt
      tbl.push_back(mk(0,0,0, 1,9, 0,9,0, 0,1, O_NORM));         // rt unused
      tbl.push_back(ahv);                                        // EX RAW on rs
      tbl.push_back(mk(0,1,5, 0,0, 5,0,0, 0,0, O_FRZ));          // freeze beats stall
      tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 1,1, O_FLSH));         // branch flush
      tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 1,0, O_FRZ));          // freeze beats flush
      tbl.push_back(mk(1,0,8, 0,0, 0,8,1, 0,1, O_STL));          // LU via rt
      tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 1,1, O_FLSH));         // flush aborts stall
      tbl.push_back(idle);                                       // no residual stall
      tbl.push_back(lw8);                                        // LU detect
      tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,1, O_STL));          // owed stall 2
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0, O_FRZ));       // memory wait
      tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,1, O_STL));          // owed stall 3 resumes
      tbl.push_back(idle);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         step($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_a);
      end

      // Hand-derived event totals after the table
      @(negedge clk);
      chk("tbl_stall_a", 32'(stall_cnt_a), 32'd9);
      chk("tbl_stall_b", 32'(stall_cnt_b), 32'd5);
      chk("tbl_flush_a", 32'(flush_cnt_a), 32'd2);
      chk("tbl_flush_b", 32'(flush_cnt_b), 32'd2);
      @(posedge clk); #1;

      // 20 ALU-hazard stalls on A: 4-bit counter must stick at 15
      drive(ahv);
      for (int i = 0; i < 20; i++) step("sat", 1'b1, O_STL);
      @(negedge clk);
      chk("sat_stall_a", 32'(stall_cnt_a), 32'd15);
      @(posedge clk); #1;

      // Async reset in the middle of a load-use stall
      drive(lw8);
      step("lu_pre_rst", 1'b1, O_STL);
      drive(idle);
      #2 reset = 1'b1;
      m_clear();
      #1;
      chk("arst_pc_a", 32'(pc_write_a), 32'd1);
      chk("arst_bub_a", 32'(id_ex_bubble_a), 32'd0);
      chk("arst_stall_a", 32'(stall_cnt_a), 32'd0);
      chk("arst_flush_a", 32'(flush_cnt_a), 32'd0);
      chk("arst_stall_b", 32'(stall_cnt_b), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      step("post_rst1", 1'b1, O_NORM);
      step("post_rst2", 1'b1, O_NORM);

      // Randomized traffic over a small register set to provoke matches
      for (int i = 0; i < 600; i++) begin
         id_ex_memread   = ($urandom_range(0, 2) == 0);
         id_ex_regwrite  = $urandom_range(0, 1);
         id_ex_rd        = 5'($urandom_range(0, 3));
         ex_mem_regwrite = $urandom_range(0, 1);
         ex_mem_rd       = 5'($urandom_range(0, 3));
         if_id_rs        = 5'($urandom_range(0, 3));
         if_id_rt        = 5'($urandom_range(0, 3));
         if_id_uses_rt   = $urandom_range(0, 1);
         branch_taken    = ($urandom_range(0, 9) == 0);
         dmem_ready      = ($urandom_range(0, 5) != 0);
         step($sformatf("rnd%0d", i), 1'b0, O_NORM);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
